soc_mem: RTL and testbench
==========================

# soc_mem

Memory-side responder for the pipelined RISC-V core, sitting at the far end of its instruction-fetch and data-memory ports. It serves both ports from one word RAM, decodes a small memory-mapped I/O window (LED register, cycle counter, halt register) and contains a byte-stream boot loader. The boot loader fills the RAM after reset and holds the core in reset until loading completes.

## Interface
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `MMIO_BASE`, default 32'h1000_0000: MMIO window base; decode compares addr[31:28] only.
- `clk`  in  1  single clock; every state element is updated on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `inst_ce_i`  in  1  instruction chip select, driven by the core.
- `inst_addr_i`  in  32  instruction byte address (core PC).
- `inst_o`  out  32  instruction word returned to the core.
- `data_ce_i`  in  1  data chip select.
- `data_we_i`  in  1  1 = store, 0 = load.
- `data_addr_i`  in  32  data byte address.
- `data_i`  in  32  store data from the core.
- `data_o`  out  32  load data to the core.
- `load_valid_i`  in  1  boot byte valid.
- `load_data_i`  in  8  boot byte.
- `load_ready_o`  out  1  loader accepts a byte this cycle.
- `cpu_rst_o`  out  1  active-high reset to the core.
- `led_o`  out  32  LED register contents.
- `halt_o`  out  1  sticky halt flag.

## Operation
- Loader FSM states are LEN0, LEN1, DATA and RUN. `rst` forces LEN0.
- A byte transfers on a cycle where `load_valid_i` and `load_ready_o` are both 1. `load_ready_o` = 1 in LEN0, LEN1 and DATA, and 0 in RUN.
- LEN0 latches len[7:0], then moves to LEN1. LEN1 latches len[15:8]; it goes to RUN if len==0, otherwise to DATA.
- DATA assembles bytes little-endian: the first byte lands in [7:0]. On every 4th byte it writes the word to RAM[word_cnt] and increments word_cnt. When word_cnt reaches len it goes to RUN.
- Words with word_cnt ≥ 2^DEPTH_LOG2 are consumed and discarded, with no wrap into low RAM.
- `cpu_rst_o` = 1 in every state except RUN.
- Instruction port: `inst_o` = RAM[inst_addr_i[DEPTH_LOG2+1:2]] when `inst_ce_i`=1, otherwise 0. The read is combinational. addr[1:0] is ignored.
- Data port, RAM region (addr[31:28] ≠ MMIO_BASE[31:28]):
  - Index is addr[DEPTH_LOG2+1:2]; upper bits alias, so accesses wrap.
  - Loads are combinational.
  - A store writes the full word at the clock edge, only when `data_ce_i`=1, `data_we_i`=1 and the state is RUN.
- Data port, MMIO region, by byte offset addr[7:0]:
  - 0x00 LED: read/write; drives `led_o`.
  - 0x04 CYCLE: read-only; writes are ignored. 32-bit counter that increments every cycle in RUN and wraps at 2^32.
  - 0x08 TOHOST: a store with nonzero data sets `halt_o`, which stays set until `rst`. Reads return {31'b0, halt_o}.
  - Any other offset reads 0; writes to it are ignored.
- `data_o` = 0 when `data_ce_i`=0 or `data_we_i`=1.
- Once `halt_o`=1, further stores are ignored. Loads still return data, and CYCLE freezes.

## Timing
- Reset values:
  - `inst_o` and `data_o` are combinational; they return 0 while the chip selects are low.
  - `load_ready_o`=1.
  - `cpu_rst_o`=1.
  - `led_o`=0.
  - `halt_o`=0.
  - CYCLE=0, word_cnt=0.
  - RAM contents are not reset.
- Reads have zero latency (same cycle). Stores take effect at the next rising edge.
- Same-cycle store and load/fetch to the same word: the read returns the old value; the new value is visible the following cycle.
- The core sees `cpu_rst_o` fall in the cycle after the final data byte, or after the LEN1 byte when len==0.
- `rst` asserted mid-load aborts the load. State returns to LEN0 and the partial word is dropped.
- `load_valid_i` is ignored in RUN.

## Structure
- Shared package `soc_mem_pkg` holds:
  - the loader state enum;
  - MMIO offset constants (LED=8'h00, CYCLE=8'h04, TOHOST=8'h08);
  - MMIO_BASE default.
- Sub-module `boot_loader` contains:
  - the LEN/DATA FSM, byte assembler and word counter;
  - outputs: a write-enable, word index and word to the RAM write mux, plus the `done` flag that drives `cpu_rst_o`.
- The top level contains the RAM array, the write mux (loader vs core), the MMIO decode and the registers.

## Test plan
- Reset, then stream bytes 02 00 13 05 A0 00 73 00 10 00 → RAM[0]=32'h00A00513, RAM[1]=32'h00100073; `cpu_rst_o` falls the cycle after the last byte; `inst_o` at addr 4 = 32'h00100073.
- len=0 (bytes 00 00) → RUN directly after the second byte; `load_ready_o`=0 from then on.
- In RUN, store 32'hDEAD_BEEF to 0x1000_0000 → `led_o`=32'hDEADBEEF next cycle; a load from 0x1000_0000 returns it.
- Load CYCLE twice, 5 cycles apart → values differ by 5. A store to CYCLE leaves it unchanged.
- Store 0 to 0x1000_0008 → `halt_o` stays 0. Store 1 → `halt_o`=1; a subsequent RAM store is ignored; a read back returns 1.
- Assert `rst` after 3 data bytes, then reload a 1-word image → only the new word is present; no partial-word write occurred.

Source files
------------

// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the soc_mem memory responder: loader states,
// MMIO register offsets and the default MMIO window base.
package soc_mem_pkg;

  typedef enum logic [1:0] {
    LD_LEN0 = 2'd0,
    LD_LEN1 = 2'd1,
    LD_DATA = 2'd2,
    LD_RUN  = 2'd3
  } ld_state_e;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;

  localparam logic [7:0] MMIO_LED    = 8'h00;
  localparam logic [7:0] MMIO_CYCLE  = 8'h04;
  localparam logic [7:0] MMIO_TOHOST = 8'h08;

  // The MMIO window is selected by the top nibble only; everything else is RAM.
  function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:28] == base[31:28];
  endfunction

endpackage

// File: rtl/soc_mem_if.sv
// Core-facing bus of soc_mem: instruction port, data port and boot byte stream.
interface soc_mem_if;

  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;

  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  logic        load_valid_i;
  logic [7:0]  load_data_i;
  logic        load_ready_o;

  modport master (
    output inst_ce_i, inst_addr_i,
    output data_ce_i, data_we_i, data_addr_i, data_i,
    output load_valid_i, load_data_i,
    input  inst_o, data_o, load_ready_o
  );

  modport slave (
    input  inst_ce_i, inst_addr_i,
    input  data_ce_i, data_we_i, data_addr_i, data_i,
    input  load_valid_i, load_data_i,
    output inst_o, data_o, load_ready_o
  );

endinterface

// File: rtl/soc_mem_boot_loader.sv
// Byte-stream boot loader: 16-bit little-endian word count, then the image bytes
// packed little-endian into words; done stays high once the image is in.
module boot_loader
  import soc_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [7:0]            load_data,
  output logic                  load_ready,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_idx,
  output logic [31:0]           wr_word,
  output logic                  done
);

  ld_state_e   state;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic        xfer;
  logic        in_range;

  assign load_ready = (state != LD_RUN);
  assign done       = (state == LD_RUN);
  assign xfer       = load_valid && load_ready;
  assign in_range   = ({16'd0, word_cnt} < (32'd1 << DEPTH_LOG2));

  // The 4th byte completes the word in the same cycle it arrives, so the RAM
  // write and the move to RUN land on the same edge.
  assign wr_en   = xfer && (state == LD_DATA) && (byte_cnt == 2'd3) && in_range;
  assign wr_idx  = word_cnt[DEPTH_LOG2-1:0];
  assign wr_word = {load_data, shift};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_LEN0;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
    end else if (xfer) begin
      case (state)
        LD_LEN0: begin
          len[7:0] <= load_data;
          state    <= LD_LEN1;
        end
        LD_LEN1: begin
          len[15:8] <= load_data;
          word_cnt  <= '0;
          byte_cnt  <= '0;
          state     <= ({load_data, len[7:0]} == 16'd0) ? LD_RUN : LD_DATA;
        end
        LD_DATA: begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            word_cnt <= word_cnt + 16'd1;
            if ((word_cnt + 16'd1) == len) state <= LD_RUN;
          end
        end
        default: state <= LD_RUN;
      endcase
    end
  end

  // Assembler bytes are pure data; a reset drops them by clearing byte_cnt.
  always_ff @(posedge clk) begin
    if (xfer && (state == LD_DATA)) shift <= {load_data, shift[23:8]};
  end

endmodule

// File: rtl/soc_mem.sv
// Memory-side responder: word RAM shared by fetch and data ports, a small MMIO
// window (LED, CYCLE, TOHOST) and a boot loader that holds the core in reset.
module soc_mem
  import soc_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  soc_mem_if.slave    bus,
  output logic        cpu_rst_o,
  output logic [31:0] led_o,
  output logic        halt_o
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           ram [0:WORDS-1];
  logic [31:0]           cycle_cnt;
  logic                  ld_we;
  logic [DEPTH_LOG2-1:0] ld_idx;
  logic [31:0]           ld_word;
  logic                  done;

  logic [DEPTH_LOG2-1:0] inst_idx;
  logic [DEPTH_LOG2-1:0] data_idx;
  logic [7:0]            mmio_off;
  logic                  mmio_sel;
  logic                  core_st;
  logic                  ram_we;
  logic [31:0]           data_rd;
  logic                  unused_addr_bits;

  boot_loader #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_valid (bus.load_valid_i),
    .load_data  (bus.load_data_i),
    .load_ready (bus.load_ready_o),
    .wr_en      (ld_we),
    .wr_idx     (ld_idx),
    .wr_word    (ld_word),
    .done       (done)
  );

  assign cpu_rst_o = !done;

  assign inst_idx = bus.inst_addr_i[DEPTH_LOG2+1:2];
  assign data_idx = bus.data_addr_i[DEPTH_LOG2+1:2];
  assign mmio_off = bus.data_addr_i[7:0];
  assign mmio_sel = is_mmio(bus.data_addr_i, MMIO_BASE);

  assign unused_addr_bits = ^{bus.inst_addr_i, bus.data_addr_i};

  // Core stores only count while it runs and has not halted.
  assign core_st = bus.data_ce_i && bus.data_we_i && done && !halt_o;
  assign ram_we  = core_st && !mmio_sel;

  always_ff @(posedge clk) begin
    if (ld_we)       ram[ld_idx]   <= ld_word;
    else if (ram_we) ram[data_idx] <= bus.data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_o     <= '0;
      halt_o    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (done && !halt_o) cycle_cnt <= cycle_cnt + 32'd1;
      if (core_st && mmio_sel && (mmio_off == MMIO_LED)) led_o <= bus.data_i;
      if (core_st && mmio_sel && (mmio_off == MMIO_TOHOST) && (bus.data_i != 32'd0))
        halt_o <= 1'b1;
    end
  end

  assign bus.inst_o = bus.inst_ce_i ? ram[inst_idx] : 32'd0;

  always_comb begin
    data_rd = '0;
    if (bus.data_ce_i && !bus.data_we_i) begin
      if (mmio_sel) begin
        case (mmio_off)
          MMIO_LED:    data_rd = led_o;
          MMIO_CYCLE:  data_rd = cycle_cnt;
          MMIO_TOHOST: data_rd = {31'd0, halt_o};
          default:     data_rd = '0;
        endcase
      end else begin
        data_rd = ram[data_idx];
      end
    end
  end

  assign bus.data_o = data_rd;

endmodule

// File: tb/tb_soc_mem.sv
// Directed bench for soc_mem: boot loading, MMIO registers, halt behaviour,
// mid-load reset, oversize images and an empty image.
module tb_soc_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rst_o;
  logic [31:0] led_o;
  logic        halt_o;
  int          total = 0;
  int          bad   = 0;

  soc_mem_if bus ();

  soc_mem dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_rst_o (cpu_rst_o),
    .led_o     (led_o),
    .halt_o    (halt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = b;
    tick();
    bus.load_valid_i = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] d);
    bus.inst_ce_i   = 1'b1;
    bus.inst_addr_i = a;
    #1;
    d = bus.inst_o;
    bus.inst_ce_i = 1'b0;
  endtask

  task automatic mem_rd(input logic [31:0] a, output logic [31:0] d);
    bus.data_ce_i   = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = a;
    #1;
    d = bus.data_o;
    bus.data_ce_i = 1'b0;
  endtask

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    bus.data_ce_i   = 1'b1;
    bus.data_we_i   = 1'b1;
    bus.data_addr_i = a;
    bus.data_i      = d;
    tick();
    bus.data_ce_i = 1'b0;
    bus.data_we_i = 1'b0;
  endtask

  logic [7:0]  img1 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
  logic [31:0] v, c1, c2;
  logic [31:0] w;

  initial begin
    bus.inst_ce_i    = 1'b0;
    bus.inst_addr_i  = '0;
    bus.data_ce_i    = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_addr_i  = '0;
    bus.data_i       = '0;
    bus.load_valid_i = 1'b0;
    bus.load_data_i  = '0;
    reset_dut();

    check_eq("rst_ready", {31'd0, bus.load_ready_o}, 32'd1);
    check_eq("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    check_eq("rst_led", led_o, 32'd0);
    check_eq("rst_halt", {31'd0, halt_o}, 32'd0);
    check_eq("rst_inst_idle", bus.inst_o, 32'd0);
    check_eq("rst_data_idle", bus.data_o, 32'd0);

    // Two-word boot image
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check_eq("img1_cpu_rst_before", {31'd0, cpu_rst_o}, 32'd1);
      send_byte(img1[i]);
    end
    check_eq("img1_cpu_rst_after", {31'd0, cpu_rst_o}, 32'd0);
    check_eq("img1_ready_run", {31'd0, bus.load_ready_o}, 32'd0);
    fetch(32'h0, v);  check_eq("img1_word0", v, 32'h00A00513);
    fetch(32'h4, v);  check_eq("img1_word1", v, 32'h00100073);
    fetch(32'h6, v);  check_eq("img1_word1_lowbits", v, 32'h00100073);
    send_byte(8'h55);
    fetch(32'h0, v);  check_eq("run_ignores_bytes", v, 32'h00A00513);

    // LED register
    bus.data_ce_i = 1'b1; bus.data_we_i = 1'b1; bus.data_addr_i = 32'h1000_0000;
    bus.data_i = 32'hDEAD_BEEF; #1;
    check_eq("store_data_o_zero", bus.data_o, 32'd0);
    tick();
    bus.data_ce_i = 1'b0; bus.data_we_i = 1'b0;
    check_eq("led_out", led_o, 32'hDEAD_BEEF);
    mem_rd(32'h1000_0000, v); check_eq("led_read", v, 32'hDEAD_BEEF);

    // CYCLE counter
    mem_rd(32'h1000_0004, c1);
    repeat (5) tick();
    mem_rd(32'h1000_0004, c2);
    check_eq("cycle_delta5", c2 - c1, 32'd5);
    mem_rd(32'h1000_0004, c1);
    mem_wr(32'h1000_0004, 32'h0);
    mem_rd(32'h1000_0004, c2);
    check_eq("cycle_store_ignored", c2 - c1, 32'd1);
    mem_rd(32'h1000_000C, v); check_eq("mmio_unmapped", v, 32'd0);

    // RAM store, same-cycle fetch sees old word, aliasing
    mem_wr(32'h0000_0100, 32'h1111_2222);
    bus.data_ce_i = 1'b1; bus.data_we_i = 1'b1; bus.data_addr_i = 32'h0000_0100;
    bus.data_i = 32'h1234_5678;
    fetch(32'h0000_0100, v); check_eq("same_cycle_old", v, 32'h1111_2222);
    tick();
    bus.data_ce_i = 1'b0; bus.data_we_i = 1'b0;
    fetch(32'h0000_0100, v); check_eq("store_visible", v, 32'h1234_5678);
    mem_rd(32'h0000_1100, v); check_eq("ram_alias", v, 32'h1234_5678);

    // TOHOST / halt
    mem_wr(32'h1000_0008, 32'h0);
    check_eq("halt_zero_store", {31'd0, halt_o}, 32'd0);
    mem_rd(32'h1000_0008, v); check_eq("tohost_read0", v, 32'd0);
    mem_wr(32'h1000_0008, 32'h1);
    check_eq("halt_set", {31'd0, halt_o}, 32'd1);
    mem_wr(32'h0000_0100, 32'hCAFE_F00D);
    mem_rd(32'h0000_0100, v); check_eq("halt_ram_store_ignored", v, 32'h1234_5678);
    mem_wr(32'h1000_0000, 32'h0);
    check_eq("halt_led_store_ignored", led_o, 32'hDEAD_BEEF);
    mem_rd(32'h1000_0008, v); check_eq("tohost_read1", v, 32'd1);
    mem_rd(32'h1000_0004, c1);
    repeat (3) tick();
    mem_rd(32'h1000_0004, c2);
    check_eq("cycle_frozen", c2, c1);

    // Reset mid-load, then a one-word image
    reset_dut();
    check_eq("halt_cleared", {31'd0, halt_o}, 32'd0);
    check_eq("led_cleared", led_o, 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    reset_dut();
    check_eq("abort_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    check_eq("reload_cpu_rst_before", {31'd0, cpu_rst_o}, 32'd1);
    send_byte(8'h77);
    check_eq("reload_cpu_rst_after", {31'd0, cpu_rst_o}, 32'd0);
    fetch(32'h0, v); check_eq("reload_word0", v, 32'h7766_5544);
    fetch(32'h4, v); check_eq("reload_word1_kept", v, 32'h0010_0073);

    // Oversize image: word 1024 must be dropped, not wrap to word 0
    reset_dut();
    send_byte(8'h01); send_byte(8'h04);
    for (int i = 0; i < 1025; i++) begin
      w = (i == 1024) ? 32'hFFFF_FFFF : (32'h100 + i);
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    end
    check_eq("big_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
    fetch(32'h0, v);     check_eq("big_word0", v, 32'h0000_0100);
    fetch(32'hFFC, v);   check_eq("big_word1023", v, 32'h0000_04FF);

    // Empty image
    reset_dut();
    send_byte(8'h00);
    check_eq("len0_cpu_rst_before", {31'd0, cpu_rst_o}, 32'd1);
    check_eq("len0_ready_before", {31'd0, bus.load_ready_o}, 32'd1);
    send_byte(8'h00);
    check_eq("len0_cpu_rst_after", {31'd0, cpu_rst_o}, 32'd0);
    check_eq("len0_ready_after", {31'd0, bus.load_ready_o}, 32'd0);
    tick();
    check_eq("len0_ready_stays", {31'd0, bus.load_ready_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
